// File: rtl/memory_arbiter_pkg.sv
// Shared widths, port indices and wait-bound defaults for the block-RAM arbiter.
package memory_arbiter_pkg;

    localparam int ADDRESS_WIDTH_DEFAULT = 16;
    localparam int DATA_WIDTH_DEFAULT    = 16;
    localparam int MAX_WAIT_DEFAULT      = 4;
    localparam int WAIT_COUNT_WIDTH      = 4;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_AUX = 1'b1
    } port_e;

endpackage

// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: the CPU has fixed
// priority, and a saturating wait counter bounds how long the aux port can be denied.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int MAX_WAIT      = MAX_WAIT_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     i_cpu_request,
    input  logic                     i_cpu_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] i_cpu_address,
    input  logic [DATA_WIDTH-1:0]    i_cpu_write_data,
    output logic                     o_cpu_grant,
    output logic                     o_cpu_read_valid,
    output logic [DATA_WIDTH-1:0]    o_cpu_read_data,

    input  logic                     i_aux_request,
    input  logic                     i_aux_write_enable,
    input  logic [ADDRESS_WIDTH-1:0] i_aux_address,
    input  logic [DATA_WIDTH-1:0]    i_aux_write_data,
    output logic                     o_aux_grant,
    output logic                     o_aux_read_valid,
    output logic [DATA_WIDTH-1:0]    o_aux_read_data,

    output logic [ADDRESS_WIDTH-1:0] o_memory_address,
    output logic [DATA_WIDTH-1:0]    o_memory_write_data,
    output logic                     o_memory_write_enable,
    input  logic [DATA_WIDTH-1:0]    i_memory_read_data
);

    localparam logic [WAIT_COUNT_WIDTH-1:0] MAX_WAIT_COUNT = WAIT_COUNT_WIDTH'(MAX_WAIT);

    logic [WAIT_COUNT_WIDTH-1:0] r_wait_count;
    logic                        r_cpu_read_valid;
    logic                        r_aux_read_valid;
    logic                        w_wait_expired;
    logic                        w_any_grant;
    port_e                       w_winner;

    // The aux port wins when the CPU is idle or once it has been denied MAX_WAIT times.
    always_comb begin
        w_wait_expired = (r_wait_count == MAX_WAIT_COUNT);
        w_any_grant    = reset && (i_cpu_request || i_aux_request);
        w_winner       = PORT_CPU;
        if (i_aux_request && (!i_cpu_request || w_wait_expired)) begin
            w_winner = PORT_AUX;
        end
    end

    assign o_cpu_grant = w_any_grant && (w_winner == PORT_CPU);
    assign o_aux_grant = w_any_grant && (w_winner == PORT_AUX);

    always_comb begin
        // NOTE: every output gets a default first so no path through the mux infers a latch.
        o_memory_address      = '0;
        o_memory_write_data   = '0;
        o_memory_write_enable = 1'b0;
        if (w_any_grant) begin
            unique case (w_winner)
                PORT_CPU: begin
                    o_memory_address      = i_cpu_address;
                    o_memory_write_data   = i_cpu_write_data;
                    o_memory_write_enable = i_cpu_write_enable;
                end
                PORT_AUX: begin
                    o_memory_address      = i_aux_address;
                    o_memory_write_data   = i_aux_write_data;
                    o_memory_write_enable = i_aux_write_enable;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: registered state is assigned non-blocking so every flop samples pre-edge values.
        if (!reset) begin
            r_wait_count     <= '0;
            r_cpu_read_valid <= 1'b0;
            r_aux_read_valid <= 1'b0;
        end else begin
            r_cpu_read_valid <= o_cpu_grant & ~i_cpu_write_enable;
            r_aux_read_valid <= o_aux_grant & ~i_aux_write_enable;
            if (o_aux_grant || !i_aux_request) begin
                r_wait_count <= '0;
            end else if (r_wait_count < MAX_WAIT_COUNT) begin
                r_wait_count <= r_wait_count + 1'b1;
            end
        end
    end

    // Both ports see the RAM data; the valid bits say whose read it was.
    assign o_cpu_read_valid = r_cpu_read_valid;
    assign o_aux_read_valid = r_aux_read_valid;
    assign o_cpu_read_data  = i_memory_read_data;
    assign o_aux_read_data  = i_memory_read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed corner cases, a vector table,
// and randomized traffic scored against a rule-level model with a shadow memory.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req, cpu_we, aux_req, aux_we;
    logic [AW-1:0] cpu_addr, aux_addr;
    logic [DW-1:0] cpu_wd, aux_wd;
    logic          cpu_grant, cpu_rv, aux_grant, aux_rv;
    logic [DW-1:0] cpu_rd, aux_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          mem_we;

    always #5 clock = ~clock;

    memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .i_cpu_request         (cpu_req),
        .i_cpu_write_enable    (cpu_we),
        .i_cpu_address         (cpu_addr),
        .i_cpu_write_data      (cpu_wd),
        .o_cpu_grant           (cpu_grant),
        .o_cpu_read_valid      (cpu_rv),
        .o_cpu_read_data       (cpu_rd),
        .i_aux_request         (aux_req),
        .i_aux_write_enable    (aux_we),
        .i_aux_address         (aux_addr),
        .i_aux_write_data      (aux_wd),
        .o_aux_grant           (aux_grant),
        .o_aux_read_valid      (aux_rv),
        .o_aux_read_data       (aux_rd),
        .o_memory_address      (mem_addr),
        .o_memory_write_data   (mem_wd),
        .o_memory_write_enable (mem_we),
        .i_memory_read_data    (mem_rd)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 16'hBEEF : ((a ^ 16'h5A00) + 16'd3);
    endfunction

    // Write-first synchronous RAM; unwritten words hold init_word().
    logic [DW-1:0] ram [logic [AW-1:0]];
    always @(posedge clock) begin
        if (mem_we) begin
            mem_rd <= mem_wd;
            ram[mem_addr] = mem_wd;
        end else begin
            mem_rd <= ram.exists(mem_addr) ? ram[mem_addr] : init_word(mem_addr);
        end
    end

    // Reference model state.
    logic [DW-1:0] shadow [logic [AW-1:0]];
    int            m_denied;
    int            aux_age;
    bit            m_cpu_rv, m_aux_rv;
    logic [DW-1:0] m_rdata;
    bit            last_cg, last_ag;
    logic          obs_cg, obs_ag, obs_we, obs_cpu_rv, obs_aux_rv;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_cpu_rd;
    int            checks = 0;
    int            failures = 0;

    typedef struct {
        bit            c_req;
        bit            c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wd;
        bit            a_req;
        bit            a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wd;
        bit            e_cg;
        bit            e_ag;
        bit            e_we;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] shadow_read(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    // One clock: checks at the falling edge, optional reset drop before the rising edge.
    task automatic run_cycle(input bit drop_reset);
        bit            m_ag, m_cg, m_we;
        logic [AW-1:0] m_addr;
        @(negedge clock);
        obs_cg     = cpu_grant;
        obs_ag     = aux_grant;
        obs_we     = mem_we;
        obs_addr   = mem_addr;
        obs_cpu_rv = cpu_rv;
        obs_aux_rv = aux_rv;
        obs_cpu_rd = cpu_rd;

        m_ag   = reset && aux_req && (!cpu_req || m_denied >= MW);
        m_cg   = reset && cpu_req && !m_ag;
        m_we   = (m_cg && cpu_we) || (m_ag && aux_we);
        m_addr = m_cg ? cpu_addr : (m_ag ? aux_addr : '0);
        last_cg = m_cg;
        last_ag = m_ag;

        check("cpu_grant", obs_cg, m_cg);
        check("aux_grant", obs_ag, m_ag);
        check("mem_write_enable", obs_we, m_we);
        check("mem_address", obs_addr, m_addr);
        if (!reset) check("mem_write_data_reset", mem_wd, 0);
        else if (m_cg || m_ag) check("mem_write_data", mem_wd, m_cg ? cpu_wd : aux_wd);
        check("cpu_read_valid", obs_cpu_rv, m_cpu_rv);
        check("aux_read_valid", obs_aux_rv, m_aux_rv);
        if (m_cpu_rv) check("cpu_read_data", obs_cpu_rd, m_rdata);
        if (m_aux_rv) check("aux_read_data", aux_rd, m_rdata);

        if (reset && aux_req) begin
            aux_age++;
            check("aux_starvation_bound", 32'(aux_age <= MW + 1), 1);
            if (obs_ag) aux_age = 0;
        end else begin
            aux_age = 0;
        end

        if (drop_reset) reset = 1'b0;

        if (!reset) begin
            m_denied = 0;
            m_cpu_rv = 0;
            m_aux_rv = 0;
            aux_age  = 0;
        end else begin
            m_cpu_rv = m_cg && !cpu_we;
            m_aux_rv = m_ag && !aux_we;
            if (m_we) shadow[m_addr] = m_cg ? cpu_wd : aux_wd;
            else if (m_cg || m_ag) m_rdata = shadow_read(m_addr);
            if (aux_req && !m_ag) m_denied = (m_denied < MW) ? m_denied + 1 : MW;
            else m_denied = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_cpu(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wd = d;
    endtask

    task automatic set_aux(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        aux_req = r; aux_we = w; aux_addr = a; aux_wd = d;
    endtask

    initial begin
        int a;
        m_denied = 0; aux_age = 0; m_cpu_rv = 0; m_aux_rv = 0; m_rdata = '0;

        vecs[0]  = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0010};
        vecs[1]  = '{1, 1, 16'h0020, 16'hAAAA, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0020};
        vecs[2]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000};
        vecs[3]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0030, 16'h5555, 0, 1, 1, 16'h0030};
        vecs[4]  = '{1, 0, 16'h0040, 16'h0000, 1, 0, 16'h0050, 16'h0000, 1, 0, 0, 16'h0040};
        vecs[5]  = '{1, 0, 16'h0041, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0041};
        vecs[6]  = '{1, 1, 16'h0042, 16'h1111, 1, 1, 16'h0052, 16'h7777, 1, 0, 1, 16'h0042};
        vecs[7]  = '{1, 0, 16'h0043, 16'h0000, 1, 1, 16'h0052, 16'h7777, 1, 0, 0, 16'h0043};
        vecs[8]  = '{1, 0, 16'h0044, 16'h0000, 1, 1, 16'h0052, 16'h7777, 1, 0, 0, 16'h0044};
        vecs[9]  = '{1, 0, 16'h0045, 16'h0000, 1, 1, 16'h0052, 16'h7777, 1, 0, 0, 16'h0045};
        vecs[10] = '{1, 0, 16'h0046, 16'h0000, 1, 1, 16'h0052, 16'h7777, 0, 1, 1, 16'h0052};
        vecs[11] = '{1, 0, 16'h0052, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0052};
        vecs[12] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000};

        // Reset held for three cycles with both ports requesting.
        set_cpu(1, 1, 16'h0100, 16'hCAFE);
        set_aux(1, 1, 16'h0300, 16'hF00D);
        repeat (3) begin
            run_cycle(0);
            check("reset_cpu_grant", obs_cg, 0);
            check("reset_aux_grant", obs_ag, 0);
            check("reset_mem_we", obs_we, 0);
        end

        // Continuous contention: aux forced in cycles 4 and 9.
        reset = 1'b1;
        a = 16'h0100;
        set_cpu(1, 0, AW'(a), 16'h0000);
        set_aux(1, 0, 16'h0300, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            run_cycle(0);
            check("contend_aux_grant", obs_ag, 32'(i % 5 == 4));
            check("contend_cpu_grant", obs_cg, 32'(i % 5 != 4));
            if (obs_cg) begin
                a++;
                cpu_addr = AW'(a);
            end
        end

        // CPU alone reads the preloaded word.
        set_aux(0, 0, 16'h0000, 16'h0000);
        set_cpu(1, 0, 16'h0010, 16'h0000);
        run_cycle(0);
        check("cpu_alone_grant", obs_cg, 1);
        set_cpu(0, 0, 16'h0000, 16'h0000);
        run_cycle(0);
        check("cpu_alone_valid", obs_cpu_rv, 1);
        check("cpu_alone_data", obs_cpu_rd, 16'hBEEF);
        check("cpu_alone_aux_valid", obs_aux_rv, 0);

        // Aux write, then a CPU read of the same word.
        set_aux(1, 1, 16'h0200, 16'h1234);
        run_cycle(0);
        check("aux_write_grant", obs_ag, 1);
        check("aux_write_we", obs_we, 1);
        check("aux_write_addr", obs_addr, 16'h0200);
        set_aux(0, 0, 16'h0000, 16'h0000);
        set_cpu(1, 0, 16'h0200, 16'h0000);
        run_cycle(0);
        check("aux_write_no_valid", obs_aux_rv, 0);
        set_cpu(0, 0, 16'h0000, 16'h0000);
        run_cycle(0);
        check("readback_valid", obs_cpu_rv, 1);
        check("readback_data", obs_cpu_rd, 16'h1234);

        // Withdrawn aux request restarts the wait count.
        set_cpu(1, 0, 16'h0400, 16'h0000);
        set_aux(1, 0, 16'h0410, 16'h0000);
        repeat (2) begin
            run_cycle(0);
            check("withdraw_pre_denied", obs_ag, 0);
        end
        aux_req = 1'b0;
        run_cycle(0);
        aux_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0);
            check("withdraw_restart", obs_ag, 32'(i == 4));
        end

        // Reset drops right after a CPU read is granted.
        set_aux(0, 0, 16'h0000, 16'h0000);
        set_cpu(1, 0, 16'h0010, 16'h0000);
        run_cycle(1);
        check("midreset_grant", obs_cg, 1);
        set_cpu(0, 0, 16'h0000, 16'h0000);
        run_cycle(0);
        check("midreset_valid_lost", obs_cpu_rv, 0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            set_cpu(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wd);
            set_aux(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wd);
            run_cycle(0);
            check($sformatf("vec%0d_cpu_grant", i), obs_cg, vecs[i].e_cg);
            check($sformatf("vec%0d_aux_grant", i), obs_ag, vecs[i].e_ag);
            check($sformatf("vec%0d_mem_we", i), obs_we, vecs[i].e_we);
            check($sformatf("vec%0d_mem_addr", i), obs_addr, vecs[i].e_addr);
        end

        // Random traffic obeying the hold-until-granted handshake.
        set_cpu(0, 0, 16'h0000, 16'h0000);
        set_aux(0, 0, 16'h0000, 16'h0000);
        last_cg = 0; last_ag = 0;
        for (int i = 0; i < 800; i++) begin
            if (!cpu_req || last_cg)
                set_cpu(($urandom % 4) != 0, $urandom % 2, AW'($urandom % 16), DW'($urandom));
            else if (($urandom % 10) == 0)
                cpu_req = 1'b0;
            if (!aux_req || last_ag)
                set_aux(($urandom % 2) != 0, $urandom % 2, AW'($urandom % 16), DW'($urandom));
            else if (($urandom % 12) == 0)
                aux_req = 1'b0;
            run_cycle(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port synchronous block RAM between two requesters: the CPU datapath/controller (instruction fetch, LOAD/STOR) and an auxiliary master (display scanout or a debug loader).
- The CPU has fixed priority. A wait counter guarantees the auxiliary port is granted within a bounded number of cycles.
- Sits between the controller/datapath memory signals and the RAM primitive.

Parameters:
- ADDRESS_WIDTH, 16, width of the word address on all ports.
- DATA_WIDTH, 16, width of the memory word.
- MAX_WAIT, 4, maximum consecutive cycles the aux port may be denied while requesting. Legal range is 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- cpu_request  input  1  CPU wants an access this cycle.
- cpu_write_enable  input  1  1 = write, 0 = read; qualified by cpu_request.
- cpu_address  input  ADDRESS_WIDTH  CPU word address.
- cpu_write_data  input  DATA_WIDTH  CPU store data.
- cpu_grant  output  1  the CPU access is issued to RAM this cycle.
- cpu_read_valid  output  1  cpu_read_data holds the data for the CPU read granted last cycle.
- cpu_read_data  output  DATA_WIDTH  read data returned to the CPU.
- aux_request  input  1  aux wants an access this cycle.
- aux_write_enable  input  1  1 = write, 0 = read.
- aux_address  input  ADDRESS_WIDTH  aux word address.
- aux_write_data  input  DATA_WIDTH  aux store data.
- aux_grant  output  1  the aux access is issued this cycle.
- aux_read_valid  output  1  aux read data valid.
- aux_read_data  output  DATA_WIDTH  read data returned to aux.
- memory_address  output  ADDRESS_WIDTH  to the RAM.
- memory_write_data  output  DATA_WIDTH  to the RAM.
- memory_write_enable  output  1  to the RAM.
- memory_read_data  input  DATA_WIDTH  from the RAM; valid one cycle after the address.

Behaviour:
- Reset: synchronous, active-low on clock; clock is the rising-edge system clock.
- While reset is low:
  - cpu_grant, aux_grant and memory_write_enable = 0.
  - memory_address and memory_write_data = 0.
  - On the clock edge, wait_count is cleared to 0 and both read_valid registers are cleared to 0.
- Grant (combinational, one winner per cycle):
  - aux wins if aux_request && (!cpu_request || wait_count == MAX_WAIT).
  - Otherwise cpu wins if cpu_request.
  - Otherwise nobody is granted.
- Issue: the winner's address, write data and write enable drive the memory_* outputs in the same cycle.
  - With no winner: memory_write_enable = 0 and memory_address = 0.
- Handshake:
  - A requester holds request, write_enable, address and write_data stable until it samples grant = 1 at a clock edge.
  - Dropping the request before grant is legal and is treated as a withdrawn request.
  - Back-to-back grants to the same port are allowed, giving one access per cycle.
- Read latency: exactly 1 cycle.
  - x_read_valid <= x_grant & ~x_write_enable, registered.
  - cpu_read_data and aux_read_data both equal memory_read_data. The valid bits qualify which port owns the data.
  - Write grants never raise read_valid.
- wait_count (4 bits, saturating) is updated at each edge:
  - cleared if aux_grant or !aux_request;
  - else incremented if aux_request && !aux_grant and wait_count < MAX_WAIT;
  - else held at MAX_WAIT.
- Starvation bound: a continuously requesting aux port is granted no later than MAX_WAIT+1 cycles after its request first rises.
  - During the forced aux cycle the CPU sees cpu_grant = 0 and must hold its request.
- Simultaneous requests with wait_count < MAX_WAIT: the CPU wins.
- Reset mid-read: a read granted in the cycle before reset drops loses its valid pulse, because the valid register is cleared on the reset edge.
- Same-address write then read on consecutive cycles: the read returns the new data. This relies on RAM write-first behaviour; the arbiter does no forwarding.

Decomposition:
- Shared package/include (memory_defines):
  - ADDRESS_WIDTH and DATA_WIDTH defaults;
  - the port index constants PORT_CPU=0 and PORT_AUX=1;
  - MAX_WAIT default.
- No sub-module. The grant logic, wait counter and valid pipeline fit in one module.

Test Plan:
- Reset held low for 3 cycles with both requests high -> both grants 0, memory_write_enable 0; after release, wait_count = 0.
- CPU alone: read at 0x0010, RAM holds 0xBEEF -> cpu_grant = 1 in cycle N; cpu_read_valid = 1 with cpu_read_data = 0xBEEF in cycle N+1; aux_read_valid stays 0.
- Both ports request continuously with MAX_WAIT = 4 -> CPU granted in cycles 0..3, aux granted in cycle 4, CPU in 5..8, aux in 9; wait_count returns to 0 after each aux grant.
- Aux write 0x1234 to 0x0200 while CPU is idle -> aux_grant = 1, memory_write_enable = 1, memory_address = 0x0200, no read_valid pulse. A following CPU read of 0x0200 returns 0x1234.
- Aux request withdrawn after 2 denied cycles, then re-raised -> wait_count restarts from 0, and aux is next forced only after 4 further denials.
- CPU read granted, then reset driven low on the next cycle -> cpu_read_valid stays 0. After reset releases, normal operation resumes.
